mem_dma: RTL and testbench

//  Memory-side initiator (DMA copy engine) that drives the single-port synchronous

---
 rtl/mem_dma_pkg.sv | 19 +
 rtl/mem_dma.sv | 162 ++++++++++++++++
 tb/tb_mem_dma.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// ---------------------------------------------------------------------------
// mem_dma_pkg
//   Shared definitions for the memory-side DMA copy engine.
//   - ISIZE / DSIZE : default address and data widths of the memory port.
//   - mem_dma_state_e : 2-bit FSM state encoding (IDLE, RD, WR, FIN).
// ---------------------------------------------------------------------------
package mem_dma_pkg;

    localparam int ISIZE = 16;
    localparam int DSIZE = 16;

    typedef enum logic [1:0] {
        MEM_DMA_IDLE = 2'd0,
        MEM_DMA_RD   = 2'd1,
        MEM_DMA_WR   = 2'd2,
        MEM_DMA_FIN  = 2'd3
    } mem_dma_state_e;

endpackage

// File: rtl/mem_dma.sv
// ---------------------------------------------------------------------------
// mem_dma
//   DMA copy engine that masters the single-port synchronous memory while
//   busy=1. On an accepted start it copies len words from src to dst, one
//   read cycle then one write cycle per word, ascending, addresses wrapping
//   modulo 2**AW. len=0 completes immediately with no write.
//
//   Optional build macro MEM_DMA_FILL_EN adds fill/fill_data: with fill=1 the
//   engine skips reads and writes fill_data to dst..dst+len-1, one word per
//   cycle. Without the macro the engine is copy-only.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   start         request pulse, honoured only in IDLE
//   src, dst, len transfer descriptor, latched with start
//   busy          high whenever the FSM is not IDLE
//   done          one-cycle pulse in the FIN cycle
//   mem_addr      memory address (holds its last value while idle)
//   mem_wen       memory write enable, forced low during reset
//   mem_wdata     write data (mem_rdata pass-through, or fill_data)
//   mem_rdata     read data for the address presented in the previous cycle
//   fill          [MEM_DMA_FILL_EN] select fill mode, latched with start
//   fill_data     [MEM_DMA_FILL_EN] constant written in fill mode
// ---------------------------------------------------------------------------
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int AW = ISIZE,
    parameter int DW = DSIZE,
    parameter int LW = AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_DMA_FILL_EN
    ,
    input  logic          fill,
    input  logic [DW-1:0] fill_data
`endif
);

    mem_dma_state_e state_q, state_d;
    logic [AW-1:0]  src_q, src_d;
    logic [AW-1:0]  dst_q, dst_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;   // last address driven, held while idle

    logic           fill_mode;        // latched fill request for this transfer
    logic           fill_req;         // fill request presented with start
    logic [DW-1:0]  fill_word;

`ifdef MEM_DMA_FILL_EN
    logic          fill_q, fill_d;
    logic [DW-1:0] fill_data_q, fill_data_d;

    assign fill_mode = fill_q;
    assign fill_req  = fill;
    assign fill_word = fill_data_q;
`else
    assign fill_mode = 1'b0;
    assign fill_req  = 1'b0;
    assign fill_word = '0;
`endif

    assign busy = (state_q != MEM_DMA_IDLE);

    // NOTE: every output and next-state value gets a default before the case
    // so no path through the block leaves a signal unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        mem_addr  = addr_q;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        done      = 1'b0;
`ifdef MEM_DMA_FILL_EN
        fill_d      = fill_q;
        fill_data_d = fill_data_q;
`endif

        unique case (state_q)
            MEM_DMA_IDLE: begin
                if (start) begin
                    src_d = src;
                    dst_d = dst;
                    cnt_d = len;
`ifdef MEM_DMA_FILL_EN
                    fill_d      = fill;
                    fill_data_d = fill_data;
`endif
                    if (len == '0)    state_d = MEM_DMA_FIN;
                    else if (fill_req) state_d = MEM_DMA_WR;
                    else               state_d = MEM_DMA_RD;
                end
            end
            MEM_DMA_RD: begin
                mem_addr = src_q;
                state_d  = MEM_DMA_WR;
            end
            MEM_DMA_WR: begin
                mem_addr  = dst_q;
                mem_wen   = 1'b1;
                // Read data arrives this cycle for the address issued in RD.
                mem_wdata = fill_mode ? fill_word : mem_rdata;
                src_d     = src_q + AW'(1);
                dst_d     = dst_q + AW'(1);
                cnt_d     = cnt_q - LW'(1);
                if (cnt_q == LW'(1)) state_d = MEM_DMA_FIN;
                else if (fill_mode)  state_d = MEM_DMA_WR;
                else                 state_d = MEM_DMA_RD;
            end
            MEM_DMA_FIN: begin
                done    = 1'b1;
                state_d = MEM_DMA_IDLE;
            end
            default: state_d = MEM_DMA_IDLE;
        endcase

        // The memory is reloading its image during reset; never write into it.
        if (rst) mem_wen = 1'b0;

        addr_d = mem_addr;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_DMA_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
`ifdef MEM_DMA_FILL_EN
            fill_q      <= 1'b0;
            fill_data_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
`ifdef MEM_DMA_FILL_EN
            fill_q      <= fill_d;
            fill_data_q <= fill_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// ---------------------------------------------------------------------------
// tb_mem_dma
//   Self-checking bench for mem_dma. A behavioural single-port synchronous
//   memory is attached to the DUT; a reference image is updated word by word
//   from the transfer rules and compared against the memory after each job.
//   Fill-mode scenarios are built only when MEM_DMA_FILL_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_dma;
    import mem_dma_pkg::*;

    localparam int AW    = ISIZE;
    localparam int DW    = DSIZE;
    localparam int LW    = AW;
    localparam int WORDS = 2**AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src, dst;
    logic [LW-1:0] len;
    logic          busy, done, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_DMA_FILL_EN
    logic          fill;
    logic [DW-1:0] fill_data;
`endif

    always #5 clk = ~clk;

    mem_dma #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_DMA_FILL_EN
        ,
        .fill      (fill),
        .fill_data (fill_data)
`endif
    );

    // Memory model: synchronous read, write on posedge, image reload on demand.
    logic [DW-1:0] img     [0:WORDS-1];
    logic [DW-1:0] mem     [0:WORDS-1];
    logic [DW-1:0] ref_mem [0:WORDS-1];
    logic          reload;

    always @(posedge clk) begin
        if (reload) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= img[i];
        end else if (mem_wen) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Per-transfer observations.
    int            wen_cnt, done_cnt, done_cyc, busy_cnt, rst_wen_bad;
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wr_q[$];

    task automatic clear_obs();
        wen_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; rst_wen_bad = 0;
        rd_q.delete();
        wr_q.delete();
    endtask

    // Sample the current cycle at negedge, then advance to just after posedge.
    task automatic tick();
        @(negedge clk);
        if (mem_wen) begin
            wen_cnt++;
            wr_q.push_back(mem_addr);
        end
        if (busy && !mem_wen && !done && !rst) rd_q.push_back(mem_addr);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (rst && mem_wen) rst_wen_bad++;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] l, output int t);
        clear_obs();
        src = s; dst = d; len = l; start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(done_cnt > 0 && !busy) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles (busy=%0b)", name, n, busy);
        end
        repeat (3) tick();
    endtask

    // Reference rules: words are moved one at a time in ascending order.
    task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        logic [AW-1:0] a, b;
        a = s; b = d;
        for (int i = 0; i < n; i++) begin
            ref_mem[b] = ref_mem[a];
            a++; b++;
        end
    endtask

    task automatic model_fill(input logic [AW-1:0] d, input int n, input logic [DW-1:0] v);
        logic [AW-1:0] b;
        b = d;
        for (int i = 0; i < n; i++) begin
            ref_mem[b] = v;
            b++;
        end
    endtask

    task automatic mem_diff(output int bad, output int first);
        bad = 0; first = -1;
        for (int i = 0; i < WORDS; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
    endtask

    // ------------------------------------------------------------------ tests

    task automatic test_reset();
        logic [AW+DW+2:0] outs;
        for (int i = 0; i < WORDS; i++) begin
            img[i]     = DW'($urandom);
            ref_mem[i] = img[i];
        end
        rst = 1'b1; reload = 1'b1; start = 1'b0;
        src = '0; dst = '0; len = '0;
`ifdef MEM_DMA_FILL_EN
        fill = 1'b0; fill_data = '0;
`endif
        clear_obs();
        repeat (3) tick();
        outs = {busy, done, mem_wen, mem_addr, mem_wdata};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%0b done=%0b wen=%0b addr=0x%h wdata=0x%h, required all 0",
                     busy, done, mem_wen, mem_addr, mem_wdata);
        end
        rst = 1'b0; reload = 1'b0;
        tick();
    endtask

    task automatic test_copy();
        int t, bad, first;
        launch(16'h0010, 16'h0100, 16'd4, t);
        wait_done("copy");
        model_copy(16'h0010, 16'h0100, 4);
        checks++;
        if (done_cyc !== t + 9) begin
            failures++;
            $display("FAIL copy_done_cycle: got T+%0d, required T+9", done_cyc - t);
        end
        checks++;
        if (wen_cnt !== 4 || done_cnt !== 1) begin
            failures++;
            $display("FAIL copy_counts: wen=%0d done=%0d, required wen=4 done=1", wen_cnt, done_cnt);
        end
        checks++;
        if (mem_addr !== 16'h0103) begin
            failures++;
            $display("FAIL copy_addr_hold: idle addr 0x%h, required 0x0103", mem_addr);
        end
        mem_diff(bad, first);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL copy_mem: %0d words differ, first 0x%h got 0x%h required 0x%h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_len_zero();
        int t, bad, first;
        clear_obs();
        src = 16'h0050; dst = 16'h0900; len = '0; start = 1'b1;
        t = cyc;
        tick();
        // Keep start high through the FIN cycle with a real job; it must be ignored.
        src = 16'h0040; dst = 16'h0500; len = 16'd2;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checks++;
        if (done_cyc !== t + 1 || done_cnt !== 1) begin
            failures++;
            $display("FAIL len0_done: got T+%0d count %0d, required T+1 count 1", done_cyc - t, done_cnt);
        end
        checks++;
        if (busy_cnt !== 1 || wen_cnt !== 0) begin
            failures++;
            $display("FAIL len0_busy_wen: busy=%0d wen=%0d cycles, required busy=1 wen=0", busy_cnt, wen_cnt);
        end
        mem_diff(bad, first);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL len0_mem: %0d words differ, first 0x%h got 0x%h required 0x%h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_wrap();
        int t, bad, first, rd_bad;
        logic [AW-1:0] a;
        launch(16'hFFFE, 16'h0200, 16'd4, t);
        wait_done("wrap");
        model_copy(16'hFFFE, 16'h0200, 4);
        rd_bad = (rd_q.size() != 4) ? 1 : 0;
        a = 16'hFFFE;
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            if (rd_q[i] !== a) rd_bad++;
            a++;
        end
        checks++;
        if (rd_bad !== 0) begin
            failures++;
            $display("FAIL wrap_read_addrs: %0d reads, first 0x%h, required 4 reads from 0xfffe",
                     rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 16'h0);
        end
        mem_diff(bad, first);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL wrap_mem: %0d words differ, first 0x%h got 0x%h required 0x%h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_start_ignored();
        int t, bad, first;
        launch(16'h0020, 16'h0400, 16'd3, t);
        tick();
        start = 1'b1; src = 16'h0700; dst = 16'h0800; len = 16'd5;
        tick();
        start = 1'b0;
        wait_done("busy_start");
        model_copy(16'h0020, 16'h0400, 3);
        checks++;
        if (done_cyc !== t + 7 || done_cnt !== 1 || wen_cnt !== 3) begin
            failures++;
            $display("FAIL busy_start: done T+%0d count %0d wen %0d, required T+7 count 1 wen 3",
                     done_cyc - t, done_cnt, wen_cnt);
        end
        mem_diff(bad, first);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL busy_start_mem: %0d words differ, first 0x%h got 0x%h required 0x%h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_reset_abort();
        int t, bad, first;
        launch(16'h0030, 16'h0600, 16'd8, t);
        repeat (3) tick();            // now in cycle T+4, the second WR
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL abort_idle: busy=%0b addr=0x%h, required busy=0 addr=0", busy, mem_addr);
        end
        repeat (5) tick();
        checks++;
        if (rst_wen_bad !== 0 || done_cnt !== 0 || wen_cnt < 1 || wen_cnt > 2) begin
            failures++;
            $display("FAIL abort_activity: wen_in_rst=%0d done=%0d writes=%0d, required 0, 0, 1..2",
                     rst_wen_bad, done_cnt, wen_cnt);
        end
        model_copy(16'h0030, 16'h0600, wen_cnt);
        mem_diff(bad, first);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL abort_mem: %0d words differ, first 0x%h got 0x%h required 0x%h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_random();
        int t, bad, first, l;
        logic [AW-1:0] s, d;
        for (int k = 0; k < 8; k++) begin
            s = AW'($urandom);
            d = (k % 2 == 0) ? AW'($urandom) : s + AW'($urandom_range(1, 3));  // odd jobs overlap
            l = $urandom_range(0, 12);
            launch(s, d, LW'(l), t);
            wait_done("random");
            model_copy(s, d, l);
            checks++;
            if (done_cyc !== t + 1 + 2 * l || wen_cnt !== l) begin
                failures++;
                $display("FAIL random_timing[%0d]: len=%0d done T+%0d wen %0d, required T+%0d wen %0d",
                         k, l, done_cyc - t, wen_cnt, 1 + 2 * l, l);
            end
            mem_diff(bad, first);
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL random_mem[%0d]: src=0x%h dst=0x%h len=%0d, %0d words differ, first 0x%h got 0x%h required 0x%h",
                         k, s, d, l, bad, first, mem[first], ref_mem[first]);
            end
        end
    endtask

`ifdef MEM_DMA_FILL_EN
    task automatic test_fill();
        int t, bad, first;
        fill = 1'b1; fill_data = 16'hA5A5;
        launch(16'h0010, 16'h0300, 16'd5, t);
        fill = 1'b0; fill_data = '0;
        wait_done("fill");
        model_fill(16'h0300, 5, 16'hA5A5);
        checks++;
        if (done_cyc !== t + 6 || wen_cnt !== 5 || rd_q.size() !== 0) begin
            failures++;
            $display("FAIL fill_timing: done T+%0d wen %0d reads %0d, required T+6 wen 5 reads 0",
                     done_cyc - t, wen_cnt, rd_q.size());
        end
        mem_diff(bad, first);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL fill_mem: %0d words differ, first 0x%h got 0x%h required 0x%h",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_copy();
        test_len_zero();
        test_wrap();
        test_start_ignored();
        test_reset_abort();
        test_random();
`ifdef MEM_DMA_FILL_EN
        test_fill();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
